// File: rtl/vga_timing_pkg.sv
// Timing constants for the 640x480 VGA link and the 160x120 monochrome bitmap,
// shared by the VGA output block and vga_capture.
package vga_timing_pkg;

  localparam int H_DISPLAY    = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_MAX        = 799;

  localparam int V_DISPLAY    = 480;
  localparam int V_SYNC_START = 513;
  localparam int V_SYNC_END   = 515;
  localparam int V_MAX        = 524;

  localparam int BASE_ADDR     = 512;
  localparam int BMP_W         = 160;
  localparam int BMP_H         = 120;
  localparam int WORDS_PER_ROW = 10;
  localparam int PIXEL_DELAY   = 1;

  typedef enum logic [1:0] {
    LK_IDLE,
    LK_HSEEN,
    LK_LOCKED
  } lock_state_e;

  // Any lit colour bit makes the bitmap pixel white.
  function automatic logic pixel_on(input logic [2:0] r, input logic [2:0] g,
                                    input logic [1:0] b);
    return |{r, g, b};
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Recovers raster position from the sync inputs: edge detect, h/v counters
// realigned on sync edges, and the lock state machine.
module vga_sync_tracker
  import vga_timing_pkg::*;
#(
  parameter int H_MAX_P        = H_MAX,
  parameter int H_SYNC_START_P = H_SYNC_START,
  parameter int V_MAX_P        = V_MAX,
  parameter int V_SYNC_START_P = V_SYNC_START
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  output logic [9:0] h_cur_o,
  output logic [9:0] v_cur_o,
  output logic       lock_next_o,
  output logic       locked_o
);

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        hs_q, vs_q;
  logic        h_edge, v_edge, h_mis, v_mis;
  lock_state_e state_q, state_d;

  // h_cur/v_cur are the position of the current sample after any sync realignment.
  always_comb begin
    h_edge  = pix_en_i & hs_q & ~hsync_i;
    v_edge  = pix_en_i & vs_q & ~vsync_i;
    h_mis   = h_edge && (h_q != 10'(H_SYNC_START_P));
    v_mis   = v_edge && (v_q != 10'(V_SYNC_START_P));
    h_cur_o = h_edge ? 10'(H_SYNC_START_P) : h_q;
    v_cur_o = v_edge ? 10'(V_SYNC_START_P) : v_q;
    h_d     = h_q;
    v_d     = v_q;
    if (pix_en_i) begin
      if (h_cur_o == 10'(H_MAX_P)) begin
        h_d = '0;
        v_d = (v_cur_o == 10'(V_MAX_P)) ? '0 : v_cur_o + 10'd1;
      end else begin
        h_d = h_cur_o + 10'd1;
        v_d = v_cur_o;
      end
    end
  end

  // Sync history resets inactive so a low sync at release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      if (pix_en_i) begin
        hs_q <= hsync_i;
        vs_q <= vsync_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LK_IDLE;
    else        state_q <= state_d;
  end

  // Decisions use state_q, i.e. the lock progress before this sample's edges.
  always_comb begin
    state_d = state_q;
    if (h_mis || v_mis) begin
      state_d = LK_IDLE;
    end else begin
      case (state_q)
        LK_IDLE:  if (h_edge) state_d = LK_HSEEN;
        LK_HSEEN: if (v_edge) state_d = LK_LOCKED;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    locked_o    = (state_q == LK_LOCKED);
    lock_next_o = (state_d == LK_LOCKED);
  end

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: subsamples the locked raster 4:1 in both directions and
// packs 16 monochrome pixels per word into screen memory.
module vga_capture
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY_P    = H_DISPLAY,
  parameter int H_MAX_P        = H_MAX,
  parameter int H_SYNC_START_P = H_SYNC_START,
  parameter int V_DISPLAY_P    = V_DISPLAY,
  parameter int V_MAX_P        = V_MAX,
  parameter int V_SYNC_START_P = V_SYNC_START,
  parameter int BASE_ADDR_P    = BASE_ADDR,
  parameter int PIXEL_DELAY_P  = PIXEL_DELAY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        HSyncIn,
  input  logic        VSyncIn,
  input  logic [2:0]  Red,
  input  logic [2:0]  Green,
  input  logic [1:0]  Blue,
  output logic [10:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        locked,
  output logic        frame_done
);

  localparam int ROW_WORDS = H_DISPLAY_P / 64;
  localparam int LAST_ADDR = BASE_ADDR_P + (V_DISPLAY_P / 4) * ROW_WORDS - 1;

  logic [9:0]  h_cur, v_cur;
  logic        lock_next;
  logic [10:0] px;
  logic [3:0]  bit_idx;
  logic        sample;
  logic [15:0] shift_q, shift_d, word_full;
  logic [10:0] addr_d;
  logic        wr_en_d, frame_done_d;

  vga_sync_tracker #(
    .H_MAX_P       (H_MAX_P),
    .H_SYNC_START_P(H_SYNC_START_P),
    .V_MAX_P       (V_MAX_P),
    .V_SYNC_START_P(V_SYNC_START_P)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .pix_en_i   (pix_en),
    .hsync_i    (HSyncIn),
    .vsync_i    (VSyncIn),
    .h_cur_o    (h_cur),
    .v_cur_o    (v_cur),
    .lock_next_o(lock_next),
    .locked_o   (locked)
  );

  // Colour lags sync, so px is the pixel the current RGB belongs to.
  always_comb begin
    px        = {1'b0, h_cur} - 11'(PIXEL_DELAY_P);
    bit_idx   = px[5:2];
    sample    = pix_en && lock_next && (px < 11'(H_DISPLAY_P)) &&
                (v_cur < 10'(V_DISPLAY_P)) && (px[1:0] == 2'd0) && (v_cur[1:0] == 2'd0);
    word_full = (bit_idx == 4'd0) ? 16'd0 : shift_q;
    word_full[bit_idx] = pixel_on(Red, Green, Blue);
    shift_d   = shift_q;
    if (pix_en && !lock_next) shift_d = '0;
    else if (sample)          shift_d = word_full;
    wr_en_d      = sample && (bit_idx == 4'd15);
    addr_d       = 11'(BASE_ADDR_P) + 11'(px[9:6]) + 11'(v_cur[9:2]) * 11'(ROW_WORDS);
    frame_done_d = wr_en_d && (addr_d == 11'(LAST_ADDR));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      wr_en      <= wr_en_d;
      frame_done <= frame_done_d;
      if (wr_en_d) begin
        wr_addr <= addr_d;
        wr_data <= word_full;
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a vertically shortened raster (8 active lines) with
// the full 800-pixel line, so whole frames fit in a short run.
module tb_vga_capture;

  localparam int HD = 640, HSS = 656, HSE = 752, HMAX = 799;
  localparam int VD = 8, VSS = 9, VSE = 11, VMAX = 11;
  localparam int BASE = 512;
  localparam int LAST = BASE + (VD / 4) * 10 - 1;

  logic        clk = 1'b0, reset = 1'b0, pix_en = 1'b0;
  logic        HSyncIn = 1'b1, VSyncIn = 1'b1;
  logic [2:0]  Red = '0, Green = '0;
  logic [1:0]  Blue = '0;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en, locked, frame_done;

  vga_capture #(.V_DISPLAY_P(VD), .V_MAX_P(VMAX), .V_SYNC_START_P(VSS)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .HSyncIn(HSyncIn), .VSyncIn(VSyncIn),
    .Red(Red), .Green(Green), .Blue(Blue), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .locked(locked), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
    logic        fd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0, miscompares = 0;
  int   wr_count = 0, fd_count = 0;
  int   tx_h = 0, tx_v = 0, sel = 0, early_line = -1, step_cnt = 0;
  logic hs_prev = 1'b1, vs_prev = 1'b1, lock_exp = 1'b0, hseen_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic white(input int s, input int px, input int v);
    if (px < 0) return 1'b0;
    case (s)
      1: return (px == 0 && v == 0) || (px == 636 && v == 4) || (px == 1 && v == 0) ||
                (px == 0 && v == 2) || (px == 64 && v == 2) || (px == 128 && v == 3) ||
                (px == 130 && v == 4);
      2: return ((px * 7 + v * 13) % 11) < 4;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input int s, input int w, input int v);
    logic [15:0] r = '0;
    for (int b = 0; b < 16; b++) r[b] = white(s, w * 64 + b * 4, v);
    return r;
  endfunction

  // One transmitted pixel clock: sync from the current count, colour for the previous pixel.
  task automatic pix_step();
    int         px;
    logic       hs, vs, h_edge, v_edge;
    logic [7:0] one, col;
    exp_t       e;
    px  = tx_h - 1;
    hs  = !((tx_h >= HSS && tx_h < HSE) || (tx_v == early_line && tx_h >= HSS - 3 && tx_h < HSS));
    vs  = !(tx_v >= VSS && tx_v < VSE);
    one = 8'd1;
    col = white(sel, px, tx_v) ? (one << (((px / 4) + tx_v) % 8)) : 8'd0;
    @(negedge clk);
    pix_en  = 1'b1;
    HSyncIn = hs;
    VSyncIn = vs;
    {Red, Green, Blue} = col;
    h_edge = hs_prev && !hs;
    v_edge = vs_prev && !vs;
    hs_prev = hs;
    vs_prev = vs;
    if (h_edge && tx_v == early_line) begin
      lock_exp  = 1'b0;
      hseen_exp = 1'b0;
    end else begin
      if (v_edge && hseen_exp) lock_exp = 1'b1;
      if (h_edge) hseen_exp = 1'b1;
    end
    if (lock_exp && px >= 0 && px < HD && tx_v < VD && (px % 64) == 60 && (tx_v % 4) == 0) begin
      e.addr = 11'(BASE + px / 64 + (tx_v / 4) * 10);
      e.data = exp_word(sel, px / 64, tx_v);
      e.fd   = (e.addr == 11'(LAST));
      exp_q.push_back(e);
    end
    if (tx_h == HMAX) begin
      tx_h = 0;
      tx_v = (tx_v == VMAX) ? 0 : tx_v + 1;
    end else begin
      tx_h++;
    end
    step_cnt++;
    // Idle cycles carry garbage on every input; nothing may be sampled then.
    if (step_cnt % 9 == 0) begin
      @(negedge clk);
      pix_en  = 1'b0;
      HSyncIn = 1'($urandom);
      VSyncIn = 1'($urandom);
      {Red, Green, Blue} = 8'($urandom);
    end
  endtask

  task automatic run_until(input int v, input int h);
    while (!(tx_v == v && tx_h == h)) pix_step();
  endtask

  task automatic run_frame();
    pix_step();
    run_until(0, 0);
  endtask

  task automatic restart_raster();
    tx_h = 0; tx_v = 0; hs_prev = 1'b1; vs_prev = 1'b1;
    lock_exp = 1'b0; hseen_exp = 1'b0;
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      exp_t e;
      wr_count++;
      if (frame_done) fd_count++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("write addr=%0d data=%04h frame_done=%0b (expect %0d %04h %0b)",
                 wr_addr, wr_data, frame_done, e.addr, e.data, e.fd);
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
        check("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end else if (frame_done) begin
      check("frame_done_without_wr_en", 32'(frame_done), 32'd0);
    end
  end

  initial begin
    int wc0, fc0;
    repeat (3) @(negedge clk);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    restart_raster();

    // Lock acquisition from reset
    run_until(VSS, 0);
    check("locked_before_vedge", 32'(locked), 32'd0);
    run_until(VSS, 2);
    check("locked_after_vedge", 32'(locked), 32'd1);
    run_until(0, 0);
    check("writes_before_lock", 32'(wr_count), 32'd0);

    // Single, corner and subsampled-away pixels
    wc0 = wr_count; fc0 = fd_count; sel = 1;
    run_frame();
    check("sparse_frame_writes", 32'(wr_count - wc0), 32'd20);
    check("sparse_frame_done_count", 32'(fd_count - fc0), 32'd1);
    check("sparse_queue_empty", 32'(exp_q.size()), 32'd0);

    // Dense pattern exercising every colour bit
    wc0 = wr_count; fc0 = fd_count; sel = 2;
    run_frame();
    check("dense_frame_writes", 32'(wr_count - wc0), 32'd20);
    check("dense_frame_done_count", 32'(fd_count - fc0), 32'd1);
    check("dense_queue_empty", 32'(exp_q.size()), 32'd0);

    // HSync edge 3 pixels early on line 2
    wc0 = wr_count; early_line = 2;
    run_until(2, HSS - 3);
    check("locked_before_misalign", 32'(locked), 32'd1);
    run_until(2, HSS - 1);
    check("locked_after_misalign", 32'(locked), 32'd0);
    run_until(VSS, 0);
    check("still_unlocked_before_vedge", 32'(locked), 32'd0);
    run_until(VSS, 2);
    check("relocked", 32'(locked), 32'd1);
    run_until(0, 0);
    early_line = -1;
    check("misalign_frame_writes", 32'(wr_count - wc0), 32'd10);
    check("misalign_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a sampled line
    run_until(4, 101);
    #2 reset = 1'b0;
    #1;
    check("midreset_wr_en", 32'(wr_en), 32'd0);
    check("midreset_wr_addr", 32'(wr_addr), 32'd0);
    check("midreset_wr_data", 32'(wr_data), 32'd0);
    check("midreset_locked", 32'(locked), 32'd0);
    check("midreset_frame_done", 32'(frame_done), 32'd0);
    check("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
    pix_en = 1'b0;
    HSyncIn = 1'b1;
    VSyncIn = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    restart_raster();
    wc0 = wr_count;
    run_frame();
    check("post_reset_frame_writes", 32'(wr_count - wc0), 32'd0);
    check("post_reset_relocked", 32'(locked), 32'd1);
    wc0 = wr_count;
    run_until(1, 0);
    check("post_reset_line0_writes", 32'(wr_count - wc0), 32'd10);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive side of the 640x480 VGA link: samples HSyncIn/VSyncIn and RGB (3/3/2), recovers the raster position, and rebuilds the 160x120 monochrome bitmap.
- Packs pixels 16 per word and writes them into screen memory at 0x200, using the same layout the VGA output block reads.
- Used for loopback self-test and frame capture.

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_MAX, 799, last h count of a line
- H_SYNC_START, 656, h count at which HSync goes low
- V_DISPLAY, 480, active lines
- V_MAX, 524, last line of a frame
- V_SYNC_START, 513, line at which VSync goes low
- BASE_ADDR, 512, word address of bitmap word 0
- PIXEL_DELAY, 1, pix_en strobes by which RGB lags sync (transmitter registers colour)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  one-cycle pixel strobe (25 MHz rate); all sampling and counting only on pix_en
- HSyncIn  in  1  horizontal sync, active-low
- VSyncIn  in  1  vertical sync, active-low
- Red  in  3  red
- Green  in  3  green
- Blue  in  2  blue
- wr_addr  out  11  bitmap word address
- wr_data  out  16  packed pixel word
- wr_en  out  1  one-cycle write strobe; memory always accepts
- locked  out  1  raster alignment valid
- frame_done  out  1  one-cycle pulse after the last word of a frame is written

Behaviour:
- Reset (async, reset=0):
  - h, v, shift register, wr_addr, wr_data: 0
  - wr_en, locked, frame_done: 0
  - HSync/VSync history registers: 1 (inactive), so there is no false edge after reset
  - Reset mid-frame discards the partial word; lock must be reacquired.
- Counting on pix_en:
  - h increments and wraps H_MAX->0.
  - On wrap, v increments and wraps V_MAX->0.
- H edge (HSyncIn=0, previous=1):
  - The current sample is defined as h=H_SYNC_START, so next h = H_SYNC_START+1.
  - If the free-running h at this sample differed from H_SYNC_START, that is an h misalign.
- V edge (VSyncIn=0, previous=1):
  - v := V_SYNC_START for the current line.
  - If v differed, that is a v misalign.
- Lock:
  - locked rises on the first V edge that follows at least one H edge with no h misalign.
  - locked falls on any misalign; it then needs the same sequence again.
- Sampling:
  - px = h - PIXEL_DELAY (11-bit, no wrap).
  - Sample when locked, px < H_DISPLAY, v < V_DISPLAY, px[1:0]=0 and v[1:0]=0.
  - bit = OR of all 8 colour bits.
  - Store into word bit (px/4)%16, LSB = leftmost pixel.
- Write:
  - On the sample with (px/4)%16=15, the next clk gives:
    - wr_en=1
    - wr_data = completed word
    - wr_addr = BASE_ADDR + px/64 + (v/4)*10
  - Latency: one clk after the 16th sample.
  - Exactly 10 writes per sampled line and 1200 per frame.
- frame_done: asserted together with wr_en for address BASE_ADDR+1199 (1711).
- Losing lock mid-word discards that word; no write is issued.
- Simultaneous H and V edge on the same sample: apply both. Lock evaluation uses the values before the edges.

Decomposition:
- Shared package vga_timing_pkg holds all timing constants:
  - display sizes, sync starts, maxima
  - BASE_ADDR, bitmap 160x120, 10 words per row
  - Both the VGA output block and vga_capture use it.
- Sub-module vga_sync_tracker: sync edge detect, h/v counters, misalign and lock logic.
- The top level does sampling, packing and write generation.

Test Plan:
- Lock acquisition: drive the ideal 800x525 raster from reset -> locked=0 until the first V edge, then 1; no wr_en before locked.
- Single pixel: white only at px=0, v=0 -> write addr 512, data 16'h0001; all other words 0.
- Corner pixel: white at px=636, v=476 -> addr 1711, data 16'h8000; frame_done pulses with that write.
- Subsampling: white only at px=1, v=0 and px=0, v=2 -> every write data is 0; exactly 1200 writes per frame.
- Misalign: shift one HSync falling edge 3 pixels early -> locked falls on that edge; no writes until the next valid V edge relocks.
- Reset mid-line: assert reset at px=100, v=40 -> all outputs 0 immediately; no spurious edge or write after release.
